// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : control_pipe
// Description : Main-control decode for the 5-stage RV64 subset core. The
//               control bundle is carried through ID/EX, EX/MEM and MEM/WB.
//               Load-use hazards are detected here and stall the front end.
// Revision    : 1.0 - initial release
// ============================================================================
module control_pipe #(
    parameter int REG_W          = 5,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op_code,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             redirect,
    output logic             stall,
    output logic             if_id_flush,
    output logic [1:0]       ex_aluop,
    output logic             ex_alusrc,
    output logic             ex_branch,
    output logic             ex_jal,
    output logic             ex_jalr,
    output logic [REG_W-1:0] ex_rd,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic [REG_W-1:0] mem_rd,
    output logic             wb_regwrite,
    output logic [1:0]       wb_memreg,
    output logic [REG_W-1:0] wb_rd,
    output logic             illegal_op
);

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    // Raw opcode table, before id_valid / rd gating
    logic       w_known;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_op_alusrc;
    logic [1:0] w_op_aluop;
    logic       w_op_branch;
    logic       w_op_jal;
    logic       w_op_jalr;
    logic       w_op_memread;
    logic       w_op_memwrite;
    logic       w_op_regwrite;
    logic [1:0] w_op_memreg;

    always_comb begin
        w_known       = 1'b1;
        w_use_rs1     = 1'b0;
        w_use_rs2     = 1'b0;
        w_op_alusrc   = 1'b0;
        w_op_aluop    = 2'b00;
        w_op_branch   = 1'b0;
        w_op_jal      = 1'b0;
        w_op_jalr     = 1'b0;
        w_op_memread  = 1'b0;
        w_op_memwrite = 1'b0;
        w_op_regwrite = 1'b0;
        w_op_memreg   = 2'b00;
        case (op_code)
            c_op_r: begin
                w_op_aluop    = 2'b10;
                w_op_regwrite = 1'b1;
                w_use_rs1     = 1'b1;
                w_use_rs2     = 1'b1;
            end
            c_op_i: begin
                w_op_alusrc   = 1'b1;
                w_op_aluop    = 2'b11;
                w_op_regwrite = 1'b1;
                w_use_rs1     = 1'b1;
            end
            c_op_load: begin
                w_op_alusrc   = 1'b1;
                w_op_memread  = 1'b1;
                w_op_regwrite = 1'b1;
                w_op_memreg   = 2'b01;
                w_use_rs1     = 1'b1;
            end
            c_op_store: begin
                w_op_alusrc   = 1'b1;
                w_op_memwrite = 1'b1;
                w_use_rs1     = 1'b1;
                w_use_rs2     = 1'b1;
            end
            c_op_branch: begin
                w_op_aluop    = 2'b01;
                w_op_branch   = 1'b1;
                w_use_rs1     = 1'b1;
                w_use_rs2     = 1'b1;
            end
            c_op_jal: begin
                w_op_jal      = 1'b1;
                w_op_regwrite = 1'b1;
                w_op_memreg   = 2'b10;
            end
            c_op_jalr: begin
                w_op_alusrc   = 1'b1;
                w_op_jalr     = 1'b1;
                w_op_regwrite = 1'b1;
                w_op_memreg   = 2'b10;
                w_use_rs1     = 1'b1;
            end
            c_op_lui: begin
                w_op_alusrc   = 1'b1;
                w_op_regwrite = 1'b1;
                w_op_memreg   = 2'b11;
            end
            default: w_known = 1'b0;
        endcase
    end

    logic w_live;
    assign w_live = id_valid & w_known;

    // Gated decode; anything not live is a bubble
    logic             w_dec_alusrc;
    logic [1:0]       w_dec_aluop;
    logic             w_dec_branch;
    logic             w_dec_jal;
    logic             w_dec_jalr;
    logic             w_dec_memread;
    logic             w_dec_memwrite;
    logic             w_dec_regwrite;
    logic [1:0]       w_dec_memreg;
    logic [REG_W-1:0] w_dec_rd;

    assign w_dec_alusrc   = w_live & w_op_alusrc;
    assign w_dec_aluop    = w_live ? w_op_aluop : 2'b00;
    assign w_dec_branch   = w_live & w_op_branch;
    assign w_dec_jal      = w_live & w_op_jal;
    assign w_dec_jalr     = w_live & w_op_jalr;
    assign w_dec_memread  = w_live & w_op_memread;
    assign w_dec_memwrite = w_live & w_op_memwrite;
    assign w_dec_regwrite = w_live & w_op_regwrite & (id_rd != '0);
    assign w_dec_memreg   = w_live ? w_op_memreg : 2'b00;
    assign w_dec_rd       = w_live ? id_rd : '0;

    // Pipeline registers
    logic             r_ex_alusrc;
    logic [1:0]       r_ex_aluop;
    logic             r_ex_branch;
    logic             r_ex_jal;
    logic             r_ex_jalr;
    logic             r_ex_memread;
    logic             r_ex_memwrite;
    logic             r_ex_regwrite;
    logic [1:0]       r_ex_memreg;
    logic [REG_W-1:0] r_ex_rd;
    logic             r_mem_memread;
    logic             r_mem_memwrite;
    logic             r_mem_regwrite;
    logic [1:0]       r_mem_memreg;
    logic [REG_W-1:0] r_mem_rd;
    logic             r_wb_regwrite;
    logic [1:0]       r_wb_memreg;
    logic [REG_W-1:0] r_wb_rd;
    logic             r_illegal;

    // Load-use detection; a zero index never creates a dependency
    logic w_rs1_act;
    logic w_rs2_act;
    logic w_haz_ex;
    logic w_haz_mem;
    logic w_hazard;
    logic w_bubble_in;

    assign w_rs1_act = w_use_rs1 & (id_rs1 != '0);
    assign w_rs2_act = w_use_rs2 & (id_rs2 != '0);
    assign w_haz_ex  = r_ex_memread & r_ex_regwrite &
                       ((w_rs1_act & (id_rs1 == r_ex_rd)) |
                        (w_rs2_act & (id_rs2 == r_ex_rd)));

    generate
        if (LOAD_USE_STALL == 2) begin : g_mem_check
            // Without forwarding the load must also clear MEM before use
            assign w_haz_mem = r_mem_memread &
                               ((w_rs1_act & (id_rs1 == r_mem_rd)) |
                                (w_rs2_act & (id_rs2 == r_mem_rd)));
        end else begin : g_no_mem_check
            assign w_haz_mem = 1'b0;
        end
    endgenerate

    assign w_hazard    = id_valid & (w_haz_ex | w_haz_mem);
    assign stall       = w_hazard & ~redirect;
    assign if_id_flush = redirect;
    assign w_bubble_in = redirect | stall;

    always_ff @(posedge clk) begin
        if (rst || w_bubble_in) begin
            r_ex_alusrc   <= 1'b0;
            r_ex_aluop    <= 2'b00;
            r_ex_branch   <= 1'b0;
            r_ex_jal      <= 1'b0;
            r_ex_jalr     <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memreg   <= 2'b00;
            r_ex_rd       <= '0;
        end else begin
            r_ex_alusrc   <= w_dec_alusrc;
            r_ex_aluop    <= w_dec_aluop;
            r_ex_branch   <= w_dec_branch;
            r_ex_jal      <= w_dec_jal;
            r_ex_jalr     <= w_dec_jalr;
            r_ex_memread  <= w_dec_memread;
            r_ex_memwrite <= w_dec_memwrite;
            r_ex_regwrite <= w_dec_regwrite;
            r_ex_memreg   <= w_dec_memreg;
            r_ex_rd       <= w_dec_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memreg   <= 2'b00;
            r_mem_rd       <= '0;
            r_wb_regwrite  <= 1'b0;
            r_wb_memreg    <= 2'b00;
            r_wb_rd        <= '0;
            r_illegal      <= 1'b0;
        end else begin
            r_mem_memread  <= r_ex_memread;
            r_mem_memwrite <= r_ex_memwrite;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memreg   <= r_ex_memreg;
            r_mem_rd       <= r_ex_rd;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memreg    <= r_mem_memreg;
            r_wb_rd        <= r_mem_rd;
            r_illegal      <= r_illegal | (id_valid & ~w_known);
        end
    end

    assign ex_alusrc    = r_ex_alusrc;
    assign ex_aluop     = r_ex_aluop;
    assign ex_branch    = r_ex_branch;
    assign ex_jal       = r_ex_jal;
    assign ex_jalr      = r_ex_jalr;
    assign ex_rd        = r_ex_rd;
    assign mem_memread  = r_mem_memread;
    assign mem_memwrite = r_mem_memwrite;
    assign mem_rd       = r_mem_rd;
    assign wb_regwrite  = r_wb_regwrite;
    assign wb_memreg    = r_wb_memreg;
    assign wb_rd        = r_wb_rd;
    assign illegal_op   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_pipe
// Description : Scoreboard bench for control_pipe, both stall depths side by
//               side, driven by directed sequences and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_pipe;

    localparam int W = 5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic         alusrc;
        logic [1:0]   aluop;
        logic         branch;
        logic         jal;
        logic         jalr;
        logic         memread;
        logic         memwrite;
        logic         regwrite;
        logic [1:0]   memreg;
        logic [W-1:0] rd;
    } bnd_t;

    typedef struct packed {
        logic stall;
        logic flush;
        bnd_t ex;
        bnd_t mem;
        bnd_t wb;
        logic ill;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [6:0]   op_code;
    logic         id_valid;
    logic [W-1:0] id_rs1, id_rs2, id_rd;
    logic         redirect;

    logic         o_stall[2], o_flush[2], o_alusrc[2], o_branch[2], o_jal[2], o_jalr[2];
    logic [1:0]   o_aluop[2], o_memreg[2];
    logic         o_memread[2], o_memwrite[2], o_regwrite[2], o_ill[2];
    logic [W-1:0] o_exrd[2], o_memrd[2], o_wbrd[2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        control_pipe #(.REG_W(W), .LOAD_USE_STALL(k + 1)) u_dut (
            .clk(clk), .rst(rst), .op_code(op_code), .id_valid(id_valid),
            .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .redirect(redirect),
            .stall(o_stall[k]), .if_id_flush(o_flush[k]),
            .ex_aluop(o_aluop[k]), .ex_alusrc(o_alusrc[k]), .ex_branch(o_branch[k]),
            .ex_jal(o_jal[k]), .ex_jalr(o_jalr[k]), .ex_rd(o_exrd[k]),
            .mem_memread(o_memread[k]), .mem_memwrite(o_memwrite[k]), .mem_rd(o_memrd[k]),
            .wb_regwrite(o_regwrite[k]), .wb_memreg(o_memreg[k]), .wb_rd(o_wbrd[k]),
            .illegal_op(o_ill[k])
        );
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q0[$];
    exp_t q1[$];

    // Reference model: the three stage slots per stall depth, newest first
    bnd_t mpipe[2][3];
    logic mill[2];

    function automatic logic known(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JR, OP_LUI};
    endfunction

    function automatic bnd_t decode(input logic [6:0] op, input logic v, input logic [W-1:0] rd);
        logic [10:0] f;
        bnd_t b;
        b = '0;
        // alusrc aluop branch jal jalr memread memwrite regwrite memreg
        case (op)
            OP_R:    f = 11'b0_10_0_0_0_0_0_1_00;
            OP_I:    f = 11'b1_11_0_0_0_0_0_1_00;
            OP_LD:   f = 11'b1_00_0_0_0_1_0_1_01;
            OP_ST:   f = 11'b1_00_0_0_0_0_1_0_00;
            OP_BR:   f = 11'b0_01_0_0_0_0_0_0_00 | 11'b0_00_1_0_0_0_0_0_00;
            OP_JAL:  f = 11'b0_00_0_1_0_0_0_1_10;
            OP_JR:   f = 11'b1_00_0_0_1_0_0_1_10;
            OP_LUI:  f = 11'b1_00_0_0_0_0_0_1_11;
            default: f = '0;
        endcase
        if (v && known(op)) begin
            {b.alusrc, b.aluop, b.branch, b.jal, b.jalr, b.memread,
             b.memwrite, b.regwrite, b.memreg} = f;
            b.rd = rd;
            if (rd == '0) b.regwrite = 1'b0;
        end
        return b;
    endfunction

    function automatic logic model_hazard(input int k);
        logic [W-1:0] src[2];
        logic         use_s[2];
        logic         h;
        h        = 1'b0;
        src[0]   = id_rs1;
        src[1]   = id_rs2;
        use_s[0] = op_code inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JR};
        use_s[1] = op_code inside {OP_R, OP_ST, OP_BR};
        for (int s = 0; s < 2; s++) begin
            if (id_valid && use_s[s] && src[s] != '0) begin
                if (mpipe[k][0].memread && mpipe[k][0].regwrite && src[s] == mpipe[k][0].rd) h = 1'b1;
                if (k == 1 && mpipe[k][1].memread && src[s] == mpipe[k][1].rd) h = 1'b1;
            end
        end
        return h;
    endfunction

    // Apply one clock edge to the model using the inputs that were presented
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic st;
            bnd_t nb;
            st = model_hazard(k) && !redirect;
            if (rst) begin
                for (int j = 0; j < 3; j++) mpipe[k][j] = '0;
                mill[k] = 1'b0;
            end else begin
                nb = (redirect || st) ? bnd_t'('0) : decode(op_code, id_valid, id_rd);
                mpipe[k][2] = mpipe[k][1];
                mpipe[k][1] = mpipe[k][0];
                mpipe[k][0] = nb;
                if (id_valid && !known(op_code)) mill[k] = 1'b1;
            end
        end
    endtask

    task automatic step(input logic [6:0] op, input logic v, input logic [W-1:0] rs1,
                        input logic [W-1:0] rs2, input logic [W-1:0] rd,
                        input logic redir, input logic r);
        exp_t e;
        @(posedge clk);
        #2;
        model_edge();
        op_code  = op;
        id_valid = v;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        redirect = redir;
        rst      = r;
        for (int k = 0; k < 2; k++) begin
            e.stall = model_hazard(k) && !redirect;
            e.flush = redirect;
            e.ex    = mpipe[k][0];
            e.mem   = mpipe[k][1];
            e.wb    = mpipe[k][2];
            e.ill   = mill[k];
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(7'h00, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lus=%0d actual=%h required=%h t=%0t", name, k + 1, act, exp, $time);
        end
    endtask

    // Monitor: compare every pending expectation mid-cycle
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            if ((k == 0 && q0.size() > 0) || (k == 1 && q1.size() > 0)) begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk("stall", k, 32'(o_stall[k]), 32'(e.stall));
                chk("flush", k, 32'(o_flush[k]), 32'(e.flush));
                chk("ex", k, 32'({o_alusrc[k], o_aluop[k], o_branch[k], o_jal[k], o_jalr[k], o_exrd[k]}),
                    32'({e.ex.alusrc, e.ex.aluop, e.ex.branch, e.ex.jal, e.ex.jalr, e.ex.rd}));
                chk("mem", k, 32'({o_memread[k], o_memwrite[k], o_memrd[k]}),
                    32'({e.mem.memread, e.mem.memwrite, e.mem.rd}));
                chk("wb", k, 32'({o_regwrite[k], o_memreg[k], o_wbrd[k]}),
                    32'({e.wb.regwrite, e.wb.memreg, e.wb.rd}));
                chk("illegal", k, 32'(o_ill[k]), 32'(e.ill));
            end
        end
    end

    logic [6:0] ops[8] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JR, OP_LUI};

    initial begin
        rst = 1'b1; op_code = OP_R; id_valid = 1'b1;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3; redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) mpipe[k][j] = '0;
            mill[k] = 1'b0;
        end

        // Reset with a valid R in ID, then release
        step(OP_R, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        step(OP_R, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        nop(4);

        // Load x5 then add x6 reading x5 in rs2, held in ID
        step(OP_LD, 1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        repeat (3) step(OP_R, 1'b1, 5'd2, 5'd5, 5'd6, 1'b0, 1'b0);
        nop(3);

        // No false stall: load x0 / use x0, and load x5 / LUI x7
        step(OP_LD, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        step(OP_R,  1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
        step(OP_LD, 1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        step(OP_LUI, 1'b1, 5'd5, 5'd5, 5'd7, 1'b0, 1'b0);
        nop(3);

        // Redirect coincident with a hazard
        step(OP_LD, 1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        step(OP_R,  1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0);
        nop(3);

        // Back-to-back loads feeding each other
        step(OP_LD, 1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        repeat (3) step(OP_LD, 1'b1, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0);
        repeat (3) step(OP_ST, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
        nop(3);

        // Reset in the middle of a stall
        step(OP_LD, 1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        step(OP_R,  1'b1, 5'd5, 5'd5, 5'd6, 1'b0, 1'b1);
        nop(3);

        // Decode sweep, then illegal opcode, then reset and invalid illegal
        for (int i = 0; i < 8; i++) step(ops[i], 1'b1, 5'd9, 5'd10, W'(i + 1), 1'b0, 1'b0);
        step(OP_BAD, 1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
        nop(4);
        step(7'h00, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        step(OP_BAD, 1'b0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
        nop(4);

        // Random traffic with small register indices to provoke hazards
        for (int i = 0; i < 800; i++) begin
            int         sel;
            logic [6:0] op;
            sel = int'($urandom_range(0, 39));
            if (sel < 36)      op = ops[sel % 8];
            else if (sel < 38) op = OP_BAD;
            else               op = 7'($urandom_range(0, 127));
            step(op, $urandom_range(0, 9) != 0,
                 W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), W'($urandom_range(0, 7)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0);
        end
        nop(2);

        @(negedge clk);
        #1;
        chk("drain", 0, 32'(q0.size()), 32'd0);
        chk("drain", 1, 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
